// File: rtl/log_scale_muldiv.sv
// Log-domain float multiply/divide: log2 LUT -> add/sub -> exp2 LUT.
// Ports: clk, rst, LUT load (lut_wr_*), in/out valid-ready, a, b, mode, result.
module log_scale_muldiv #(
  parameter int FLOAT_LEN  = 16,
  parameter int EXP_LEN    = 5,
  parameter int MANT_LEN   = 10,
  parameter int LUT_ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lut_wr_en,
  input  logic [MANT_LEN-1:0]  log2_lut_data_in,
  input  logic [MANT_LEN-1:0]  exp2_lut_data_in,
  output logic                 lut_wr_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOAT_LEN-1:0] result
);
  localparam int LUT_SIZE = 1 << LUT_ADDR_W;
  localparam int EW = EXP_LEN + 2;
  typedef logic signed [EW-1:0] exp_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  localparam exp_t BIAS = exp_t'((1 << (EXP_LEN-1)) - 1);
  localparam exp_t EMAX = exp_t'((1 << EXP_LEN) - 1);
  localparam exp_t EMIN = exp_t'(1 - MANT_LEN);
  localparam exp_t ONE  = exp_t'(1);
  localparam logic [EXP_LEN-1:0] EXP_ONES = '1;
  localparam logic [MANT_LEN-1:0] NAN_M =
    {1'b1, {(MANT_LEN-1){1'b0}}};

  // LUT storage and loader
  logic [MANT_LEN-1:0] r_log2_lut [LUT_SIZE];
  logic [MANT_LEN-1:0] r_exp2_lut [LUT_SIZE];
  logic [LUT_ADDR_W-1:0] r_wr_ptr;
  logic r_wr_done;
  logic w_lut_we;

  assign w_lut_we = lut_wr_en & ~r_wr_done;

  always_ff @(posedge clk) begin
    if (w_lut_we) begin
      r_log2_lut[r_wr_ptr] <= log2_lut_data_in;
      r_exp2_lut[r_wr_ptr] <= exp2_lut_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_wr_done <= 1'b0;
    end else if (w_lut_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (&r_wr_ptr) r_wr_done <= 1'b1;
    end
  end

  // Handshake: each stage moves when its successor is free
  logic r_v1, r_v2, r_v3;
  logic w_free1, w_free2, w_free3, w_accept;

  assign w_free3  = ~r_v3 | out_ready;
  assign w_free2  = ~r_v2 | w_free3;
  assign w_free1  = ~r_v1 | w_free2;
  assign in_ready = r_wr_done & w_free1;
  assign w_accept = in_valid & in_ready;

  // Stage 1 inputs: classify, unbias, log2 lookup
  logic [EXP_LEN-1:0]  w_ae, w_be;
  logic [MANT_LEN-1:0] w_am, w_bm;
  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;
  spec_t w_spec;

  assign w_ae = a[FLOAT_LEN-2 -: EXP_LEN];
  assign w_be = b[FLOAT_LEN-2 -: EXP_LEN];
  assign w_am = a[MANT_LEN-1:0];
  assign w_bm = b[MANT_LEN-1:0];
  assign w_a_inf  = (w_ae == EXP_ONES) && (w_am == '0);
  assign w_a_nan  = (w_ae == EXP_ONES) && (w_am != '0);
  assign w_a_zero = (w_ae == '0);
  assign w_b_inf  = (w_be == EXP_ONES) && (w_bm == '0);
  assign w_b_nan  = (w_be == EXP_ONES) && (w_bm != '0);
  assign w_b_zero = (w_be == '0);

  // NaN outranks inf, inf outranks zero
  always_comb begin
    w_spec = SP_NONE;
    if (w_a_nan | w_b_nan) begin
      w_spec = SP_NAN;
    end else if (!mode) begin
      if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf))
        w_spec = SP_NAN;
      else if (w_a_inf | w_b_inf)
        w_spec = SP_INF;
      else if (w_a_zero | w_b_zero)
        w_spec = SP_ZERO;
    end else begin
      if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf))
        w_spec = SP_NAN;
      else if (w_a_inf | w_b_zero)
        w_spec = SP_INF;
      else if (w_a_zero | w_b_inf)
        w_spec = SP_ZERO;
    end
  end

  logic r1_sign, r1_mode;
  spec_t r1_spec;
  exp_t r1_ea, r1_eb;
  logic [MANT_LEN-1:0] r1_la, r1_lb;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r1_sign <= a[FLOAT_LEN-1] ^ b[FLOAT_LEN-1];
      r1_mode <= mode;
      r1_spec <= w_spec;
      r1_ea   <= $signed({2'b00, w_ae}) - BIAS;
      r1_eb   <= $signed({2'b00, w_be}) - BIAS;
      r1_la   <= r_log2_lut[w_am[MANT_LEN-1 -: LUT_ADDR_W]];
      r1_lb   <= r_log2_lut[w_bm[MANT_LEN-1 -: LUT_ADDR_W]];
    end
  end

  // Stage 2: add/sub in the log domain, carry/borrow into E
  logic [MANT_LEN:0] w_lsum, w_ldif;
  exp_t w_esum, w_edif, w_e;
  logic [MANT_LEN-1:0] w_l;

  assign w_lsum = {1'b0, r1_la} + {1'b0, r1_lb};
  assign w_ldif = {1'b0, r1_la} - {1'b0, r1_lb};
  assign w_esum = r1_ea + r1_eb;
  assign w_edif = r1_ea - r1_eb;

  always_comb begin
    w_l = w_lsum[MANT_LEN-1:0];
    w_e = w_lsum[MANT_LEN] ? w_esum + ONE : w_esum;
    if (r1_mode) begin
      w_l = w_ldif[MANT_LEN-1:0];
      w_e = w_ldif[MANT_LEN] ? w_edif - ONE : w_edif;
    end
  end

  logic r2_sign;
  spec_t r2_spec;
  exp_t r2_e;
  logic [LUT_ADDR_W-1:0] r2_idx;

  always_ff @(posedge clk) begin
    if (r_v1 & w_free2) begin
      r2_sign <= r1_sign;
      r2_spec <= r1_spec;
      r2_e    <= w_e;
      r2_idx  <= w_l[MANT_LEN-1 -: LUT_ADDR_W];
    end
  end

  // Stage 3: exp2 lookup, rebias, range select and pack
  logic [MANT_LEN-1:0] w_m;
  exp_t w_eb, w_sh;
  logic [MANT_LEN:0] w_sub;
  logic [FLOAT_LEN-1:0] w_packed;
  logic w_unused;

  assign w_m  = r_exp2_lut[r2_idx];
  assign w_eb = r2_e + BIAS;
  assign w_sh = ONE - w_eb;
  assign w_sub = {1'b1, w_m} >> w_sh;
  assign w_unused = ^w_l ^ w_sub[MANT_LEN];

  always_comb begin
    w_packed = {r2_sign, {(FLOAT_LEN-1){1'b0}}};
    unique case (r2_spec)
      SP_NAN:  w_packed = {r2_sign, EXP_ONES, NAN_M};
      SP_INF:  w_packed = {r2_sign, EXP_ONES, {MANT_LEN{1'b0}}};
      SP_ZERO: w_packed = {r2_sign, {(FLOAT_LEN-1){1'b0}}};
      SP_NONE: begin
        if (w_eb >= EMAX)
          w_packed = {r2_sign, EXP_ONES, {MANT_LEN{1'b0}}};
        else if (w_eb >= ONE)
          w_packed = {r2_sign, w_eb[EXP_LEN-1:0], w_m};
        else if (w_eb >= EMIN)
          w_packed = {r2_sign, {EXP_LEN{1'b0}},
                      w_sub[MANT_LEN-1:0]};
      end
    endcase
  end

  logic [FLOAT_LEN-1:0] r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_free1) r_v1 <= w_accept;
      if (w_free2) r_v2 <= r_v1;
      if (w_free3) r_v3 <= r_v2;
      if (w_free3 & r_v2) r_result <= w_packed;
    end
  end

  assign lut_wr_done = r_wr_done;
  assign out_valid   = r_v3;
  assign result      = r_result;
endmodule

// File: tb/tb_log_scale_muldiv.sv
// Self-checking bench for log_scale_muldiv (FP16 config) against an
// integer fixed-point reference model with a scoreboard queue.
module tb_log_scale_muldiv;
  logic clk = 1'b0;
  logic rst;
  logic lut_wr_en;
  logic [9:0] log2_in, exp2_in;
  logic lut_wr_done;
  logic in_valid, in_ready;
  logic [15:0] a, b;
  logic mode;
  logic out_valid, out_ready;
  logic [15:0] result;

  int n_chk = 0;
  int n_fail = 0;

  logic [9:0] log_tab [128];
  logic [9:0] exp_tab [128];

  always #5 clk = ~clk;

  log_scale_muldiv dut (
    .clk(clk),
    .rst(rst),
    .lut_wr_en(lut_wr_en),
    .log2_lut_data_in(log2_in),
    .exp2_lut_data_in(exp2_in),
    .lut_wr_done(lut_wr_done),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
  );

  // Reference: value = exponent*1024 + log fraction, floor-split after op
  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic md);
    int xe, ye, xm, ym, t, e, l, eb, m, sm;
    bit xn, yn, xi, yi, xz, yz;
    logic s;
    s = x[15] ^ y[15];
    xe = int'(x[14:10]); ye = int'(y[14:10]);
    xm = int'(x[9:0]);   ym = int'(y[9:0]);
    xn = (xe == 31) && (xm != 0); yn = (ye == 31) && (ym != 0);
    xi = (xe == 31) && (xm == 0); yi = (ye == 31) && (ym == 0);
    xz = (xe == 0); yz = (ye == 0);
    if (xn || yn) return {s, 5'h1f, 10'h200};
    if (!md) begin
      if ((xi && yz) || (xz && yi)) return {s, 5'h1f, 10'h200};
      if (xi || yi) return {s, 5'h1f, 10'h000};
      if (xz || yz) return {s, 15'h0};
      t = (xe - 15) * 1024 + int'(log_tab[xm >> 3])
        + (ye - 15) * 1024 + int'(log_tab[ym >> 3]);
    end else begin
      if ((xz && yz) || (xi && yi)) return {s, 5'h1f, 10'h200};
      if (xi || yz) return {s, 5'h1f, 10'h000};
      if (xz || yi) return {s, 15'h0};
      t = (xe - 15) * 1024 + int'(log_tab[xm >> 3])
        - ((ye - 15) * 1024 + int'(log_tab[ym >> 3]));
    end
    e = t >>> 10;
    l = t & 1023;
    m = int'(exp_tab[l >> 3]);
    eb = e + 15;
    if (eb >= 31) return {s, 5'h1f, 10'h000};
    if (eb >= 1) return {s, eb[4:0], m[9:0]};
    if (eb >= -9) begin
      sm = (1024 + m) >> (1 - eb);
      return {s, 5'h00, sm[9:0]};
    end
    return {s, 15'h0};
  endfunction

  task automatic write_entry(input logic [9:0] l, input logic [9:0] e);
    lut_wr_en = 1'b1;
    log2_in = l;
    exp2_in = e;
    @(negedge clk);
    lut_wr_en = 1'b0;
  endtask

  task automatic one_op(input logic [15:0] x, input logic [15:0] y,
                        input logic md, output logic [15:0] r,
                        output int lat);
    a = x; b = y; mode = md;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk); lat++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    r = result;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; lut_wr_en = 1'b0; log2_in = '0; exp2_in = '0;
    in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({out_valid, lut_wr_done, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got ov/done/rdy=%b want 000",
               {out_valid, lut_wr_done, in_ready});
    end
    n_chk++;
    if (result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0000", result);
    end
  endtask

  task automatic test_lut_load;
    for (int i = 0; i < 50; i++)
      write_entry(10'($urandom), 10'($urandom));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({lut_wr_done, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL midload_reset: got done/rdy=%b want 00",
               {lut_wr_done, in_ready});
    end
    for (int i = 0; i < 127; i++)
      write_entry(log_tab[i], exp_tab[i]);
    n_chk++;
    if ({lut_wr_done, in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL load_127: got done/rdy=%b want 00",
               {lut_wr_done, in_ready});
    end
    write_entry(log_tab[127], exp_tab[127]);
    n_chk++;
    if ({lut_wr_done, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL load_128: got done/rdy=%b want 11",
               {lut_wr_done, in_ready});
    end
    for (int i = 0; i < 5; i++)
      write_entry(10'h3ff, 10'h3ff);
  endtask

  task automatic test_directed;
    logic [15:0] r;
    int lat;
    one_op(16'h3C00, 16'h3C00, 1'b0, r, lat);
    n_chk++;
    if (r !== 16'h3C00) begin
      n_fail++;
      $display("FAIL one_x_one: got %h want 3c00", r);
    end
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL latency: got %0d want 3", lat);
    end
    one_op(16'h4000, 16'h3800, 1'b1, r, lat);
    n_chk++;
    if (r !== 16'h4400) begin
      n_fail++;
      $display("FAIL two_div_half: got %h want 4400", r);
    end
    one_op(16'h7800, 16'h7800, 1'b0, r, lat);
    n_chk++;
    if (r !== 16'h7C00) begin
      n_fail++;
      $display("FAIL overflow: got %h want 7c00", r);
    end
  endtask

  task automatic test_specials;
    logic [15:0] ta [8];
    logic [15:0] tb [8];
    logic [15:0] te [8];
    logic tm [8];
    logic [15:0] r;
    int lat;
    ta = '{16'h7C00, 16'h3C00, 16'hBC00, 16'h7E01,
           16'h0000, 16'h7C00, 16'hFC00, 16'h0200};
    tb = '{16'h0000, 16'h0000, 16'h7C00, 16'h4500,
           16'h0000, 16'h7C00, 16'h0000, 16'h3C00};
    tm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    te = '{16'h7E00, 16'h7C00, 16'h8000, 16'h7E00,
           16'h7E00, 16'h7E00, 16'hFE00, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      one_op(ta[i], tb[i], tm[i], r, lat);
      n_chk++;
      if (r !== te[i]) begin
        n_fail++;
        $display("FAIL special_%0d: a=%h b=%h m=%b got %h want %h",
                 i, ta[i], tb[i], tm[i], r, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] q [$];
    logic [15:0] xs [6];
    logic [15:0] ys [6];
    logic ms [6];
    logic [15:0] held, exp_r;
    bit hv;
    int sent, got, cyc;
    for (int i = 0; i < 6; i++) begin
      xs[i] = 16'($urandom);
      xs[i][14:10] = 5'($urandom_range(22, 8));
      ys[i] = 16'($urandom);
      ys[i][14:10] = 5'($urandom_range(22, 8));
      ms[i] = 1'($urandom);
    end
    sent = 0; got = 0; cyc = 0; hv = 1'b0; held = '0;
    while (got < 6 && cyc < 60) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        a = xs[sent]; b = ys[sent]; mode = ms[sent];
      end
      out_ready = (cyc >= 5);
      #1;
      n_chk++;
      if (in_ready !== ((q.size() < 3) || out_ready)) begin
        n_fail++;
        $display("FAIL b2b_in_ready cyc %0d: got %b buffered %0d",
                 cyc, in_ready, q.size());
      end
      if (hv) begin
        n_chk++;
        if ({out_valid, result} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL b2b_stall_hold: got %b/%h want 1/%h",
                   out_valid, result, held);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_r = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        n_chk++;
        if (result !== exp_r) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: got %h want %h",
                   got, result, exp_r);
        end
        got++;
      end
      hv = out_valid && !out_ready;
      held = result;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (got !== 6 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 6, left %0d",
               got, q.size());
    end
  endtask

  task automatic test_random;
    logic [15:0] q [$];
    logic [15:0] exp_r;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 300 && cyc < 3000) begin
      in_valid = (sent < 300) && ($urandom_range(9, 0) < 7);
      a = 16'($urandom);
      b = 16'($urandom);
      mode = 1'($urandom);
      out_ready = ($urandom_range(9, 0) < 7);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_r = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        n_chk++;
        if (result !== exp_r) begin
          n_fail++;
          $display("FAIL random_%0d: got %h want %h",
                   got, result, exp_r);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got !== 300) begin
      n_fail++;
      $display("FAIL random_count: got %0d want 300", got);
    end
  endtask

  task automatic test_reset_pipeline;
    logic [15:0] r;
    int n, cyc, lat;
    bit seen;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h3C00; b = 16'h3C00; mode = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 20) begin
      #1;
      if (in_ready) n++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (n !== 3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill: got %0d accepted ov=%b want 3/1",
               n, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({out_valid, lut_wr_done, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL pipe_reset: got ov/done/rdy=%b want 000",
               {out_valid, lut_wr_done, in_ready});
    end
    n_chk++;
    if (result !== 16'h0000) begin
      n_fail++;
      $display("FAIL pipe_reset_result: got %h want 0000", result);
    end
    for (int i = 0; i < 128; i++)
      write_entry(log_tab[i], exp_tab[i]);
    n_chk++;
    if (lut_wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reload: got done=%b want 1", lut_wr_done);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_output: got out_valid after reset want 0");
    end
    one_op(16'h3C00, 16'h3C00, 1'b0, r, lat);
    n_chk++;
    if (r !== 16'h3C00 || lat !== 3) begin
      n_fail++;
      $display("FAIL post_reset_op: got %h lat %0d want 3c00 lat 3",
               r, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      log_tab[i] = 10'($urandom);
      exp_tab[i] = 10'($urandom);
    end
    log_tab[0] = '0;
    exp_tab[0] = '0;
    test_reset();
    test_lut_load();
    test_directed();
    test_specials();
    test_back_to_back();
    test_random();
    test_reset_pipeline();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/log_scale_muldiv.md
LOG_SCALE_MULDIV -- requirements
Module: log_scale_muldiv

Interface
REQ-001 SHALL have parameter FLOAT_LEN, default 16, total float width.
REQ-002 SHALL have parameter EXP_LEN, default 5, exponent field width.
REQ-003 SHALL have parameter MANT_LEN, default 10, mantissa field width.
REQ-004 SHALL have parameter LUT_ADDR_W, default 7, LUT index width; LUT_SIZE = 2^LUT_ADDR_W; LUT_ADDR_W <= MANT_LEN.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port lut_wr_en, input, 1, write one entry into each LUT this cycle.
REQ-008 SHALL have port log2_lut_data_in, input, MANT_LEN, log2 fraction entry.
REQ-009 SHALL have port exp2_lut_data_in, input, MANT_LEN, exp2 fraction entry.
REQ-010 SHALL have port lut_wr_done, output, 1, both LUTs fully loaded.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-012 SHALL have ports a and b, input, FLOAT_LEN each, operands.
REQ-013 SHALL have port mode, input, 1, 0 = a*b, 1 = a/b.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1), output handshake.
REQ-015 SHALL have port result, output, FLOAT_LEN, packed float result.

Function
REQ-016 SHALL write both LUTs at entry wr_ptr and increment wr_ptr on each lut_wr_en while lut_wr_done=0.
REQ-017 SHALL set lut_wr_done on the cycle after the LUT_SIZE-th write, and ignore lut_wr_en afterwards.
REQ-018 SHALL drive in_ready = lut_wr_done AND (stage-1 empty OR stage 1 advancing); an operand is accepted when in_valid AND in_ready.
REQ-019 SHALL implement a 3-stage pipeline with a valid bit per stage; a stage advances only if its successor is empty or advancing; stage 3 advances only on out_ready or when empty.
REQ-020 SHALL give a latency of 3 cycles from acceptance to out_valid with out_ready held high, and a throughput of 1 result per cycle.
REQ-021 SHALL hold result and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 Stage 1 SHALL unpack the operands, unbias the exponents (bias = 2^(EXP_LEN-1)-1) into EXP_LEN+2-bit signed values, and look up log2 via index mant[MANT_LEN-1 -: LUT_ADDR_W] for a and b (two read ports, one table).
REQ-023 Stage 2, mode 0: L = la+lb and E = ea+eb; on carry out of MANT_LEN bits, L wraps and E+1.
REQ-024 Stage 2, mode 1: L = la-lb and E = ea-eb; on borrow, L = L + 2^MANT_LEN and E-1.
REQ-025 Stage 3 SHALL look up exp2 at L[MANT_LEN-1 -: LUT_ADDR_W] and form Eb = E + bias.
REQ-026 Stage 3 SHALL pack normal results as {sign, Eb, exp2}, where sign = sa XOR sb.
REQ-027 For Eb >= 2^EXP_LEN-1, the result SHALL be infinity {sign, all ones, 0}.
REQ-028 For 1-MANT_LEN <= Eb <= 0, the result SHALL be subnormal: mant = {1, exp2} >> (1-Eb), exponent field 0.
REQ-029 For Eb < 1-MANT_LEN, the result SHALL be signed zero.
REQ-030 Input subnormals (exponent field 0) SHALL be treated as zero.
REQ-031 Special cases SHALL override the normal path:
- NaN input, inf*0, 0/0 or inf/inf -> {sign, all ones, MSB-only mantissa}
- inf operand in mul, inf/x or x/0 -> signed inf
- zero operand in mul, 0/x or x/inf -> signed zero
REQ-032 The special-case flags SHALL be pipelined alongside the data so they are aligned to stage 3.

Reset
REQ-033 rst SHALL clear wr_ptr, lut_wr_done, all stage valids, out_valid and result (0); in_ready=0 after reset.
REQ-034 LUT storage SHALL NOT be reset; a reset mid-load restarts loading from entry 0; a reset mid-pipeline discards in-flight operands.

Verification
REQ-035 Load 127 entries, then check lut_wr_done=0 and in_ready=0; load the 128th, then lut_wr_done=1 one cycle later; further lut_wr_en leaves tables unchanged.
REQ-036 With LUT entry 0 = 0 in both tables: a=0x3C00, b=0x3C00, mode=0 -> result 0x3C00, out_valid exactly 3 cycles after acceptance.
REQ-037 a=0x4000, b=0x3800, mode=1 -> 0x4400; a=0x7800, b=0x7800, mode=0 -> 0x7C00 (overflow).
REQ-038 Specials: 0x7C00*0x0000 -> 0x7E00; 0x3C00/0x0000 -> 0x7C00; 0xBC00/0x7C00 (mode 1) -> 0x8000; 0x7E01*any -> NaN.
REQ-039 Stream 6 back-to-back operands with out_ready low for 5 cycles -> no loss or duplication; in_ready drops once 3 results are buffered; results emerge in order.
REQ-040 Assert rst for 1 cycle mid-load and again with the pipeline full -> wr_ptr=0, lut_wr_done=0, out_valid=0 on the next cycle.
